// File: rtl/avmm_wr_burst_tracker_pkg.sv
// -----------------------------------------------------------------------------
// avmm_wr_burst_tracker_pkg
// Shared constants for the AVMM write-burst tracker slice.
//   LOCAL_MEM_BURST_CNT_WIDTH        : burstcount width of the local-memory AVMM ports
//   WR_TRACK_MAX_OUTSTANDING_DEFAULT : default number of bursts that may await a response
// -----------------------------------------------------------------------------
package avmm_wr_burst_tracker_pkg;

   localparam int LOCAL_MEM_BURST_CNT_WIDTH        = 7;
   localparam int WR_TRACK_MAX_OUTSTANDING_DEFAULT = 64;

endpackage : avmm_wr_burst_tracker_pkg

// File: rtl/avmm_wr_burst_tracker_fifo.sv
// -----------------------------------------------------------------------------
// avmm_burstcnt_fifo
// Synchronous first-word-fall-through FIFO holding one burstcount per burst.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears pointers/count)
//   push        : write push_data this cycle (ignored when full and not popping)
//   push_data   : burstcount to store
//   pop         : discard the head entry (ignored when empty)
//   head        : current head entry, valid whenever empty=0 (zero latency)
//   count       : number of stored entries, 0..DEPTH
//   full, empty : derived from count
// -----------------------------------------------------------------------------
module avmm_burstcnt_fifo #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == DEPTH_CNT);
   assign empty     = (count_r == {(AW+1){1'b0}});
   // A push while full is only taken if a pop frees a slot in the same cycle.
   assign push_ok_s = push & (~full | pop);
   assign pop_ok_s  = pop & ~empty;
   assign head      = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Storage array: written on accepted pushes, no reset needed.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers wrap naturally at power-of-two depth; occupancy tracked in count_r.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule : avmm_burstcnt_fifo

// File: rtl/avmm_wr_burst_tracker.sv
// -----------------------------------------------------------------------------
// avmm_wr_burst_tracker
// Remembers the burstcount of every write burst accepted by local memory and
// returns it alongside the matching per-burst write response, in order.
// New bursts are held off while the tracking FIFO is full.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   host_write         : kernel-side write request
//   host_burstcount    : burstcount, sampled on the first beat of a burst
//   host_waitrequest   : kernel-side backpressure (combinational)
//   dev_write          : memory-side write request (combinational)
//   dev_waitrequest    : memory-side backpressure
//   dev_wr_resp_valid  : one pulse per completed burst from memory
//   burst_ack_out      : per-burst ack towards the burst-to-word converter
//   burstcnt_out       : burstcount of the acked burst (valid with burst_ack_out)
//   outstanding        : bursts accepted but not yet acked
//   err_underflow      : sticky, response seen with nothing outstanding
//   err_zero_burst     : sticky, first beat carried burstcount 0
// -----------------------------------------------------------------------------
module avmm_wr_burst_tracker
   import avmm_wr_burst_tracker_pkg::*;
#(
   parameter int AVMM_BURSTCNT_WIDTH = LOCAL_MEM_BURST_CNT_WIDTH,
   parameter int MAX_OUTSTANDING     = WR_TRACK_MAX_OUTSTANDING_DEFAULT
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               host_write,
   input  logic [AVMM_BURSTCNT_WIDTH-1:0]     host_burstcount,
   output logic                               host_waitrequest,
   output logic                               dev_write,
   input  logic                               dev_waitrequest,
   input  logic                               dev_wr_resp_valid,
   output logic                               burst_ack_out,
   output logic [AVMM_BURSTCNT_WIDTH-1:0]     burstcnt_out,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
   output logic                               err_underflow,
   output logic                               err_zero_burst
);

   localparam int BCW = AVMM_BURSTCNT_WIDTH;

   logic [BCW-1:0] beats_left_r;
   logic [BCW-1:0] beats_left_nxt_s;
   logic [BCW-1:0] push_data_s;
   logic           first_beat_s;
   logic           block_s;
   logic           accept_s;
   logic           push_s;
   logic           zero_bc_s;
   logic           fifo_full_s;
   logic           fifo_empty_s;
   logic           err_underflow_r;
   logic           err_zero_burst_r;

   // Only a new burst can be blocked; beats of an accepted burst always pass.
   assign first_beat_s     = (beats_left_r == BCW'(0));
   assign block_s          = first_beat_s & fifo_full_s;
   assign dev_write        = host_write & ~block_s;
   assign host_waitrequest = dev_waitrequest | block_s;
   assign accept_s         = dev_write & ~dev_waitrequest;
   assign push_s           = accept_s & first_beat_s;
   assign zero_bc_s        = (host_burstcount == BCW'(0));
   // A zero burstcount is tracked as a single-beat burst.
   assign push_data_s      = zero_bc_s ? BCW'(1) : host_burstcount;
   assign burst_ack_out    = dev_wr_resp_valid & ~fifo_empty_s;
   assign err_underflow    = err_underflow_r;
   assign err_zero_burst   = err_zero_burst_r;

   avmm_burstcnt_fifo #(
      .WIDTH (BCW),
      .DEPTH (MAX_OUTSTANDING)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (burst_ack_out),
      .head      (burstcnt_out),
      .count     (outstanding),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // Next remaining-beat count for the burst in progress.
   always_comb begin
      beats_left_nxt_s = beats_left_r;
      if (accept_s && first_beat_s) begin
         if (zero_bc_s) begin
            beats_left_nxt_s = BCW'(0);
         end else begin
            beats_left_nxt_s = host_burstcount - BCW'(1);
         end
      end else if (accept_s) begin
         beats_left_nxt_s = beats_left_r - BCW'(1);
      end else begin
         beats_left_nxt_s = beats_left_r;
      end
   end

   // Beat counter and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         beats_left_r     <= BCW'(0);
         err_underflow_r  <= 1'b0;
         err_zero_burst_r <= 1'b0;
      end else begin
         beats_left_r <= beats_left_nxt_s;
         if (dev_wr_resp_valid && fifo_empty_s) begin
            err_underflow_r <= 1'b1;
         end
         if (push_s && zero_bc_s) begin
            err_zero_burst_r <= 1'b1;
         end
      end
   end

endmodule : avmm_wr_burst_tracker
